// File: rtl/cisr_row_decoder.sv
// CISR row decoder: assigns a global row index to every nonzero consumed by one channel.
// Optional zero-length row reporting is enabled by defining CISR_EMPTY_ROW_EN.
`ifndef DIM_W
`define DIM_W 16
`endif

module cisr_row_decoder #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = `DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spmv_init,
    input  logic              start,
    input  logic [DATA_W-1:0] len_in,
    input  logic              len_empty,
    output logic              pop_len,
    output logic              row_req,
    input  logic              row_gnt,
    input  logic [ROW_W-1:0]  row_gnt_id,
    input  logic              row_gnt_last,
    input  logic              slot_valid,
    output logic [ROW_W-1:0]  row_id,
    output logic              busy,
    output logic              done,
    output logic              underflow
`ifdef CISR_EMPTY_ROW_EN
    ,
    output logic              empty_row_valid,
    output logic [ROW_W-1:0]  empty_row_id
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ROW_W-1:0]  cur_row;
    logic [DATA_W-1:0] remaining;
    logic              clr;
    logic              len_zero;
    logic              consume;

    assign clr      = !rst_n || spmv_init;
    assign len_zero = (len_in == '0);
    assign consume  = (state == S_ACTIVE) && slot_valid;

    always_comb begin
        state_nx = state;
        row_req  = 1'b0;
        pop_len  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_REQ;
            end
            S_REQ: begin
                row_req = 1'b1;
                if (row_gnt) state_nx = row_gnt_last ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (!len_empty) begin
                    pop_len  = 1'b1;
                    state_nx = len_zero ? S_REQ : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (slot_valid && remaining == DATA_W'(1)) state_nx = S_REQ;
            end
            S_DONE: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
        // Handshakes stay quiet for the whole cycle in which a clear is applied.
        if (clr) begin
            row_req = 1'b0;
            pop_len = 1'b0;
        end
    end

    assign done = (state == S_DONE) && !clr;
    assign busy = (state == S_REQ) || (state == S_LOAD) || (state == S_ACTIVE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            cur_row   <= '0;
            remaining <= '0;
            row_id    <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_REQ && row_gnt && !row_gnt_last) cur_row <= row_gnt_id;
            if (pop_len && !len_zero) remaining <= len_in;
            if (consume && remaining != '0) remaining <= remaining - DATA_W'(1);
            if (consume) row_id <= cur_row;
            if (slot_valid && state != S_ACTIVE) underflow <= 1'b1;
        end
    end

`ifdef CISR_EMPTY_ROW_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            empty_row_valid <= 1'b0;
            empty_row_id    <= '0;
        end else begin
            empty_row_valid <= pop_len && len_zero;
            if (pop_len && len_zero) empty_row_id <= cur_row;
        end
    end
`endif

endmodule

// File: tb/tb_cisr_row_decoder.sv
// Self-checking bench for cisr_row_decoder: directed vector table, hand-written
// corner sequences, then randomized rows checked against a row-ownership model.
module tb_cisr_row_decoder;

    localparam int DW = 32;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n, spmv_init, start, len_empty, pop_len, row_req;
    logic          row_gnt, row_gnt_last, slot_valid, busy, done, underflow;
    logic [DW-1:0] len_in;
    logic [RW-1:0] row_gnt_id, row_id;
`ifdef CISR_EMPTY_ROW_EN
    logic          empty_row_valid;
    logic [RW-1:0] empty_row_id;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cisr_row_decoder #(.DATA_W(DW), .ROW_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .spmv_init(spmv_init), .start(start),
        .len_in(len_in), .len_empty(len_empty), .pop_len(pop_len),
        .row_req(row_req), .row_gnt(row_gnt), .row_gnt_id(row_gnt_id),
        .row_gnt_last(row_gnt_last), .slot_valid(slot_valid), .row_id(row_id),
        .busy(busy), .done(done), .underflow(underflow)
`ifdef CISR_EMPTY_ROW_EN
        , .empty_row_valid(empty_row_valid), .empty_row_id(empty_row_id)
`endif
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        start        = 1'b0;
        spmv_init    = 1'b0;
        len_empty    = 1'b1;
        len_in       = '0;
        row_gnt      = 1'b0;
        row_gnt_id   = '0;
        row_gnt_last = 1'b0;
        slot_valid   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          st, le;
        logic [DW-1:0] len;
        logic          g;
        logic [RW-1:0] gid;
        logic          gl, sv;
        logic          e_req, e_pop, e_busy, e_done;
        logic [RW-1:0] e_row;
        logic          e_uf;
    } vec_t;

    function automatic vec_t mkv(input logic st, le, input logic [DW-1:0] len,
                                 input logic g, input logic [RW-1:0] gid, input logic gl, sv,
                                 input logic e_req, e_pop, e_busy, e_done,
                                 input logic [RW-1:0] e_row, input logic e_uf);
        vec_t v;
        v.st = st; v.le = le; v.len = len; v.g = g; v.gid = gid; v.gl = gl; v.sv = sv;
        v.e_req = e_req; v.e_pop = e_pop; v.e_busy = e_busy; v.e_done = e_done;
        v.e_row = e_row; v.e_uf = e_uf;
        return v;
    endfunction

    vec_t tbl[16];

    // random-phase model state
    bit          need_grant, need_len, fin;
    int          slots_left, granted, cyc;
    logic [RW-1:0] cur_id, exp_row;
    logic [RW-1:0] owner_q[$];
    int unsigned r;

    initial begin
        rst_n = 1'b0;
        idle_in();

        // inputs: st le len g gid gl sv | expected: req pop busy done row_id uf
        tbl[0]  = mkv(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 1, 0, 1, 5, 0, 0,  1, 0, 1, 0, 0, 0);
        tbl[2]  = mkv(0, 0, 3, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        tbl[3]  = mkv(0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
        tbl[4]  = mkv(0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 5, 0);
        tbl[5]  = mkv(0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 5, 0);
        tbl[6]  = mkv(0, 1, 0, 1, 7, 0, 0,  1, 0, 1, 0, 5, 0);
        tbl[7]  = mkv(0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 5, 0);
        tbl[8]  = mkv(0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 0, 5, 0);
        tbl[9]  = mkv(0, 1, 0, 1, 2, 0, 0,  1, 0, 1, 0, 7, 0);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 7, 0);
        tbl[11] = mkv(0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 7, 0);
        tbl[12] = mkv(0, 1, 0, 1, 9, 1, 0,  1, 0, 1, 0, 7, 0);
        tbl[13] = mkv(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 7, 0);
        tbl[14] = mkv(1, 1, 0, 1, 3, 0, 0,  0, 0, 0, 1, 7, 0);
        tbl[15] = mkv(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 7, 0);

        // reset state
        @(negedge clk);
        #1;
        chk1("rst_req", row_req, 1'b0);
        chk1("rst_pop", pop_len, 1'b0);
        chk1("rst_done", done, 1'b0);
        do_reset();
        #1;
        chk1("reset_busy", busy, 1'b0);
        chkw("reset_row_id", 64'(row_id), 64'd0);
        chk1("reset_uf", underflow, 1'b0);

        // directed table: basic row, last grant, empty row, DONE holding
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            start = tbl[i].st; len_empty = tbl[i].le; len_in = tbl[i].len;
            row_gnt = tbl[i].g; row_gnt_id = tbl[i].gid; row_gnt_last = tbl[i].gl;
            slot_valid = tbl[i].sv;
            #1;
            chk1($sformatf("v%0d_req", i), row_req, tbl[i].e_req);
            chk1($sformatf("v%0d_pop", i), pop_len, tbl[i].e_pop);
            chk1($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk1($sformatf("v%0d_done", i), done, tbl[i].e_done);
            chkw($sformatf("v%0d_row_id", i), 64'(row_id), 64'(tbl[i].e_row));
            chk1($sformatf("v%0d_uf", i), underflow, tbl[i].e_uf);
            chk1($sformatf("v%0d_excl", i), row_req & pop_len, 1'b0);
`ifdef CISR_EMPTY_ROW_EN
            chk1($sformatf("v%0d_erv", i), empty_row_valid, (i == 11));
            if (i == 11) chkw("v11_erid", 64'(empty_row_id), 64'd2);
`endif
        end

        // FIFO-empty stall in LOAD, then underflow in REQ
        do_reset();
        start = 1'b1;
        @(negedge clk); idle_in(); row_gnt = 1'b1; row_gnt_id = 3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); idle_in();
            #1;
            chk1($sformatf("stall%0d_pop", k), pop_len, 1'b0);
            chk1($sformatf("stall%0d_busy", k), busy, 1'b1);
            chk1($sformatf("stall%0d_req", k), row_req, 1'b0);
        end
        @(negedge clk); idle_in(); len_empty = 1'b0; len_in = 2;
        #1;
        chk1("stall_pop5", pop_len, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle_in(); slot_valid = 1'b1;
        end
        @(negedge clk); idle_in(); slot_valid = 1'b1;
        #1;
        chkw("stall_row_id", 64'(row_id), 64'd3);
        chk1("stall_uf", underflow, 1'b0);
        chk1("stall_req_after", row_req, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle_in();
            #1;
            chk1($sformatf("uf_sticky%0d", k), underflow, 1'b1);
            chkw($sformatf("uf_row_id%0d", k), 64'(row_id), 64'd3);
        end
        @(negedge clk); idle_in(); spmv_init = 1'b1;
        #1;
        chk1("init_req_gated", row_req, 1'b0);
        @(negedge clk); idle_in();
        #1;
        chk1("init_uf_clear", underflow, 1'b0);
        chkw("init_row_id", 64'(row_id), 64'd0);
        chk1("init_busy", busy, 1'b0);

        // mid-row spmv_init with remaining=4, then a fresh pass
        start = 1'b1;
        @(negedge clk); idle_in(); row_gnt = 1'b1; row_gnt_id = 4;
        @(negedge clk); idle_in(); len_empty = 1'b0; len_in = 6;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle_in(); slot_valid = 1'b1;
        end
        @(negedge clk); idle_in(); spmv_init = 1'b1; slot_valid = 1'b1; start = 1'b1;
        #1;
        chkw("mid_row_id_pre", 64'(row_id), 64'd4);
        @(negedge clk); idle_in();
        #1;
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_req", row_req, 1'b0);
        chk1("mid_pop", pop_len, 1'b0);
        chk1("mid_done", done, 1'b0);
        chkw("mid_row_id", 64'(row_id), 64'd0);
        chk1("mid_uf", underflow, 1'b0);
        start = 1'b1;
        @(negedge clk); idle_in(); row_gnt = 1'b1; row_gnt_id = 6;
        #1; chk1("mid2_req", row_req, 1'b1);
        @(negedge clk); idle_in(); len_empty = 1'b0; len_in = 1;
        #1; chk1("mid2_pop", pop_len, 1'b1);
        @(negedge clk); idle_in(); slot_valid = 1'b1;
        @(negedge clk); idle_in();
        #1;
        chkw("mid2_row_id", 64'(row_id), 64'd6);
        chk1("mid2_req_again", row_req, 1'b1);

        // rst_n wins over start and grant in the same cycle
        @(negedge clk); idle_in(); rst_n = 1'b0; start = 1'b1; row_gnt = 1'b1; row_gnt_id = 8;
        #1; chk1("rstpri_req", row_req, 1'b0);
        @(negedge clk); idle_in(); rst_n = 1'b1;
        #1;
        chk1("rstpri_busy", busy, 1'b0);
        chkw("rstpri_row_id", 64'(row_id), 64'd0);

        // randomized rows against a row-ownership model
        do_reset();
        start = 1'b1;
        need_grant = 1'b0; need_len = 1'b0; fin = 1'b0;
        slots_left = 0; granted = 0; cyc = 0; exp_row = '0; cur_id = '0;
        @(posedge clk);
        need_grant = 1'b1;
        while (!fin && cyc < 20000) begin
            cyc++;
            @(negedge clk);
            idle_in();
            start = ($urandom % 16 == 0);
            if (need_grant && ($urandom % 2 == 0)) begin
                row_gnt      = 1'b1;
                row_gnt_id   = RW'($urandom);
                row_gnt_last = (granted == 30);
            end else if (!need_grant && ($urandom % 8 == 0)) begin
                row_gnt      = 1'b1;
                row_gnt_id   = RW'($urandom);
                row_gnt_last = 1'($urandom);
            end
            len_empty = need_len ? ($urandom % 3 == 0) : 1'($urandom);
            r = $urandom % 10;
            if (r < 3)       len_in = '0;
            else if (r == 3) len_in = DW'(256 + $urandom % 4);
            else             len_in = DW'(1 + $urandom % 4);
            slot_valid = (slots_left > 0) && ($urandom % 3 != 0);
            #1;
            chk1("rnd_req", row_req, need_grant);
            chk1("rnd_pop", pop_len, need_len && !len_empty);
            chkw("rnd_row_id", 64'(row_id), 64'(exp_row));
            chk1("rnd_uf", underflow, 1'b0);
            chk1("rnd_busy", busy, 1'b1);
            @(posedge clk);
            if (row_gnt && need_grant) begin
                if (row_gnt_last) begin
                    fin = 1'b1;
                    need_grant = 1'b0;
                end else begin
                    granted++;
                    cur_id = row_gnt_id;
                    need_grant = 1'b0;
                    need_len = 1'b1;
                end
            end else if (need_len && !len_empty) begin
                need_len = 1'b0;
                if (len_in == '0) need_grant = 1'b1;
                else begin
                    slots_left = int'(len_in);
                    for (int k = 0; k < slots_left; k++) owner_q.push_back(cur_id);
                end
            end else if (slot_valid) begin
                exp_row = owner_q.pop_front();
                slots_left--;
                if (slots_left == 0) need_grant = 1'b1;
            end
        end
        chk1("rnd_finished", fin, 1'b1);
        @(negedge clk); idle_in();
        #1;
        chk1("rnd_done", done, 1'b1);
        chk1("rnd_done_busy", busy, 1'b0);
        chkw("rnd_final_row_id", 64'(row_id), 64'(exp_row));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
